baser_66b_mlane_checker: RTL and testbench
==========================================

BASER_66B_MLANE_CHECKER -- requirements
Module: baser_66b_mlane_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload bits per 66b block.
REQ-002 SHALL have parameter HDR_WIDTH, default 2, sync header bits per block.
REQ-003 SHALL have parameter FRAME_WIDTH, default DATA_WIDTH+HDR_WIDTH, bits per coded block.
REQ-004 SHALL have parameter NUM_LANES, default 4, coded blocks per cycle, range 1..8.
REQ-005 SHALL have parameter LOCK_CNT, default 64, consecutive good headers needed for lock.
REQ-006 SHALL have parameter BAD_SH_MAX, default 16, bad headers per 64-block window forcing lock loss.
REQ-007 SHALL have parameter DATA_CHAR_PATTERN, default 8'hAA, expected payload byte in data blocks.
REQ-008 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-009 SHALL have ports: i_rst  in  1  reset, synchronous, active-high.
REQ-010 SHALL have ports: i_valid  in  1  qualifies i_rx_coded this cycle.
REQ-011 SHALL have ports: i_rx_coded  in  NUM_LANES*FRAME_WIDTH  lane k at bits [k*FRAME_WIDTH +: FRAME_WIDTH]; header at lane bits [1:0], block type at [9:2].
REQ-012 SHALL have ports: o_block_lock  out  NUM_LANES  per-lane lock flag.
REQ-013 SHALL have ports: o_block_count, o_data_count, o_ctrl_count, o_inv_sh_count, o_inv_type_count, o_lock_loss_count, o_inv_pattern_count  out  32 each  statistics.

Function
REQ-014 SHALL ignore i_rx_coded, leaving all state unchanged, in cycles with i_valid=0.
REQ-015 SHALL classify each valid lane: header 2'b01 data; 2'b10 control; 2'b00/2'b11 invalid SH.
REQ-016 SHALL flag a control lane as invalid type when type is not in {1E,78,4B,87,99,AA,B4,CC,D2,E1,FF}.
REQ-017 SHALL add, per valid cycle, NUM_LANES to block_count and the per-category lane sums to data, ctrl, inv_sh, inv_type counters in the same update.
REQ-018 SHALL update all counters and o_block_lock exactly 1 cycle after the sampling edge (registered outputs).
REQ-019 SHALL saturate every counter at 32'hFFFF_FFFF; no wrap-around.
REQ-020 SHALL run one lock FSM per lane, states UNLOCKED and LOCKED; o_block_lock[k]=1 only in LOCKED.
REQ-021 UNLOCKED: good-header run counter +1 per valid good header, cleared to 0 on bad header; reaching LOCK_CNT -> LOCKED, run counter cleared.
REQ-022 LOCKED: 6-bit window counter counts valid blocks, bad-header counter counts invalid SH; window wrap 63->0 clears bad count.
REQ-023 LOCKED: bad count reaching BAD_SH_MAX -> UNLOCKED, both counters cleared, o_lock_loss_count +1 per lane lost that cycle.
REQ-024 SHALL give precedence to lock loss when BAD_SH_MAX and window wrap coincide on the same block.
REQ-025 SHALL keep statistics counting independent of lock state.

Reset
REQ-026 SHALL, on i_rst=1 at a clock edge, clear all counters to 0, o_block_lock to 0, all FSMs to UNLOCKED, internal counters to 0.
REQ-027 SHALL let reset override i_valid in the same cycle, including mid-lock and mid-window.
REQ-028 SHALL resume sampling on the first edge with i_rst=0.

Configuration
REQ-029 SHALL, with BASER_CHK_PATTERN_EN defined, increment o_inv_pattern_count by the number of valid data lanes whose payload bytes are not all DATA_CHAR_PATTERN.
REQ-030 SHALL, without BASER_CHK_PATTERN_EN, keep the port, tie o_inv_pattern_count to 0, and omit comparator logic.

Verification
REQ-031 Reset, then 64 valid cycles with all 4 lanes header 01, payload AA -> o_block_lock=4'hF one cycle after 64th; block_count=256, data_count=256.
REQ-032 Locked; lane 2 gets header 00 on 16 consecutive valid cycles -> lane 2 drops after 16th; lock_loss_count=1; inv_sh_count=16.
REQ-033 Locked; lane 0 gets 15 bad headers in window 1, 15 in window 2 -> lock held; inv_sh_count=30.
REQ-034 Header 10 with type 0x1F on lane 1 for 1 cycle -> inv_type_count=1, ctrl_count=1.
REQ-035 BASER_CHK_PATTERN_EN defined, one data lane payload 0x55 bytes -> inv_pattern_count=1; undefined -> 0.
REQ-036 Counters preloaded near max (force 32'hFFFF_FFFE) plus 4 lanes -> 32'hFFFF_FFFF; i_rst mid-run -> all zero next cycle.

Source files
------------

// File: rtl/baser_66b_mlane_checker.sv
// ---------------------------------------------------------------------------
// baser_66b_mlane_checker
//
// Purpose:
//   Multi-lane 64b/66b block checker. Every valid cycle it classifies the
//   coded blocks on each lane as data, control or invalid sync header. It
//   flags control blocks whose type is unknown, keeps 32-bit saturating
//   statistics and runs a block-lock state machine for each lane.
//
// Optional feature (compile-time macro):
//   BASER_CHK_PATTERN_EN - when defined, valid data lanes whose payload bytes
//                          are not all DATA_CHAR_PATTERN are counted in
//                          o_inv_pattern_count. When undefined, that output is
//                          tied to zero and no comparator logic is built.
//
// Ports:
//   clk                  single clock, rising edge
//   i_rst                synchronous active-high reset
//   i_valid              qualifies i_rx_coded this cycle
//   i_rx_coded           NUM_LANES coded blocks; lane k at [k*FRAME_WIDTH +:
//                        FRAME_WIDTH], header at lane bits [1:0], block type
//                        at lane bits [9:2]
//   o_block_lock         per-lane block lock flag
//   o_block_count        total blocks seen
//   o_data_count         blocks with header 01
//   o_ctrl_count         blocks with header 10
//   o_inv_sh_count       blocks with header 00 or 11
//   o_inv_type_count     control blocks with an unknown block type
//   o_lock_loss_count    lane lock-loss events
//   o_inv_pattern_count  data blocks with unexpected payload bytes
// ---------------------------------------------------------------------------
module baser_66b_mlane_checker #(
   parameter int         DATA_WIDTH        = 64,
   parameter int         HDR_WIDTH         = 2,
   parameter int         FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH,
   parameter int         NUM_LANES         = 4,
   parameter int         LOCK_CNT          = 64,
   parameter int         BAD_SH_MAX        = 16,
   parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA
) (
   input  logic                             clk,
   input  logic                             i_rst,
   input  logic                             i_valid,
   input  logic [NUM_LANES*FRAME_WIDTH-1:0] i_rx_coded,
   output logic [NUM_LANES-1:0]             o_block_lock,
   output logic [31:0]                      o_block_count,
   output logic [31:0]                      o_data_count,
   output logic [31:0]                      o_ctrl_count,
   output logic [31:0]                      o_inv_sh_count,
   output logic [31:0]                      o_inv_type_count,
   output logic [31:0]                      o_lock_loss_count,
   output logic [31:0]                      o_inv_pattern_count
);

   localparam int SUM_W = $clog2(NUM_LANES + 1);
   localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam int BAD_W = (BAD_SH_MAX > 1) ? $clog2(BAD_SH_MAX) : 1;

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [SUM_W-1:0] b);
      logic [32:0] s;
      s = {1'b0, a} + 33'(b);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic ctrl_type_ok(input logic [7:0] t);
      case (t)
         8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
         8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   // ---- stage p0: per-lane classification and lane sums ------------------
   logic [NUM_LANES-1:0] is_data_p0;
   logic [NUM_LANES-1:0] is_ctrl_p0;
   logic [NUM_LANES-1:0] is_bad_sh_p0;
   logic [NUM_LANES-1:0] is_bad_type_p0;
   logic [NUM_LANES-1:0] lose_p0;
   logic [NUM_LANES-1:0] pat_bad_p0;

   logic [SUM_W-1:0] data_sum_p0;
   logic [SUM_W-1:0] ctrl_sum_p0;
   logic [SUM_W-1:0] bad_sh_sum_p0;
   logic [SUM_W-1:0] bad_type_sum_p0;
   logic [SUM_W-1:0] lose_sum_p0;
   logic [SUM_W-1:0] pat_sum_p0;

   genvar g;
   for (g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [HDR_WIDTH-1:0] hdr;
      logic [7:0]           typ;
      logic [0:0]           state_p1;
      logic [RUN_W-1:0]     run_p1;
      logic [5:0]           win_p1;
      logic [BAD_W-1:0]     bad_p1;

      assign hdr = i_rx_coded[g*FRAME_WIDTH +: HDR_WIDTH];
      assign typ = i_rx_coded[g*FRAME_WIDTH + 2 +: 8];

      assign is_data_p0[g]     = (hdr[1:0] == 2'b01);
      assign is_ctrl_p0[g]     = (hdr[1:0] == 2'b10);
      assign is_bad_sh_p0[g]   = (hdr[1:0] == 2'b00) || (hdr[1:0] == 2'b11);
      assign is_bad_type_p0[g] = is_ctrl_p0[g] && !ctrl_type_ok(typ);

      // The bad header that would bring the window count to BAD_SH_MAX drops
      // the lane even when it is also the last block of the window.
      assign lose_p0[g] = i_valid && (state_p1 == ST_LOCKED) && is_bad_sh_p0[g] &&
                          (bad_p1 == BAD_W'(BAD_SH_MAX - 1));

`ifdef BASER_CHK_PATTERN_EN
      localparam int NBYTES = DATA_WIDTH / 8;
      assign pat_bad_p0[g] = is_data_p0[g] &&
         (i_rx_coded[g*FRAME_WIDTH + HDR_WIDTH +: NBYTES*8] != {NBYTES{DATA_CHAR_PATTERN}});
`else
      assign pat_bad_p0[g] = 1'b0;
`endif

      // ---- stage p1: per-lane lock state ---------------------------------
      always_ff @(posedge clk) begin
         if (i_rst) begin
            state_p1 <= ST_UNLOCKED;
            run_p1   <= '0;
            win_p1   <= '0;
            bad_p1   <= '0;
         end else if (i_valid) begin
            case (state_p1)
               ST_UNLOCKED: begin
                  if (is_bad_sh_p0[g]) begin
                     run_p1 <= '0;
                  end else if (run_p1 == RUN_W'(LOCK_CNT - 1)) begin
                     state_p1 <= ST_LOCKED;
                     run_p1   <= '0;
                     win_p1   <= '0;
                     bad_p1   <= '0;
                  end else begin
                     run_p1 <= run_p1 + RUN_W'(1);
                  end
               end
               default: begin
                  if (lose_p0[g]) begin
                     state_p1 <= ST_UNLOCKED;
                     win_p1   <= '0;
                     bad_p1   <= '0;
                  end else if (win_p1 == 6'd63) begin
                     win_p1 <= '0;
                     bad_p1 <= '0;
                  end else begin
                     win_p1 <= win_p1 + 6'd1;
                     bad_p1 <= bad_p1 + BAD_W'(is_bad_sh_p0[g]);
                  end
               end
            endcase
         end
      end

      assign o_block_lock[g] = (state_p1 == ST_LOCKED);
   end

   always_comb begin
      data_sum_p0     = '0;
      ctrl_sum_p0     = '0;
      bad_sh_sum_p0   = '0;
      bad_type_sum_p0 = '0;
      lose_sum_p0     = '0;
      pat_sum_p0      = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         data_sum_p0     = data_sum_p0     + SUM_W'(is_data_p0[k]);
         ctrl_sum_p0     = ctrl_sum_p0     + SUM_W'(is_ctrl_p0[k]);
         bad_sh_sum_p0   = bad_sh_sum_p0   + SUM_W'(is_bad_sh_p0[k]);
         bad_type_sum_p0 = bad_type_sum_p0 + SUM_W'(is_bad_type_p0[k]);
         lose_sum_p0     = lose_sum_p0     + SUM_W'(lose_p0[k]);
         pat_sum_p0      = pat_sum_p0      + SUM_W'(pat_bad_p0[k]);
      end
   end

   // ---- stage p1: statistics registers -----------------------------------
   logic [31:0] blk_cnt_p1;
   logic [31:0] dat_cnt_p1;
   logic [31:0] ctl_cnt_p1;
   logic [31:0] ish_cnt_p1;
   logic [31:0] ity_cnt_p1;
   logic [31:0] ll_cnt_p1;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         blk_cnt_p1 <= '0;
         dat_cnt_p1 <= '0;
         ctl_cnt_p1 <= '0;
         ish_cnt_p1 <= '0;
         ity_cnt_p1 <= '0;
         ll_cnt_p1  <= '0;
      end else if (i_valid) begin
         blk_cnt_p1 <= sat_add(blk_cnt_p1, SUM_W'(NUM_LANES));
         dat_cnt_p1 <= sat_add(dat_cnt_p1, data_sum_p0);
         ctl_cnt_p1 <= sat_add(ctl_cnt_p1, ctrl_sum_p0);
         ish_cnt_p1 <= sat_add(ish_cnt_p1, bad_sh_sum_p0);
         ity_cnt_p1 <= sat_add(ity_cnt_p1, bad_type_sum_p0);
         ll_cnt_p1  <= sat_add(ll_cnt_p1, lose_sum_p0);
      end
   end

   assign o_block_count     = blk_cnt_p1;
   assign o_data_count      = dat_cnt_p1;
   assign o_ctrl_count      = ctl_cnt_p1;
   assign o_inv_sh_count    = ish_cnt_p1;
   assign o_inv_type_count  = ity_cnt_p1;
   assign o_lock_loss_count = ll_cnt_p1;

`ifdef BASER_CHK_PATTERN_EN
   logic [31:0] pat_cnt_p1;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         pat_cnt_p1 <= '0;
      end else if (i_valid) begin
         pat_cnt_p1 <= sat_add(pat_cnt_p1, pat_sum_p0);
      end
   end

   assign o_inv_pattern_count = pat_cnt_p1;
`else
   // Payload bits beyond the block type only feed the pattern comparator.
   logic unused_payload;
   assign unused_payload = ^{i_rx_coded, DATA_CHAR_PATTERN, pat_sum_p0};

   assign o_inv_pattern_count = '0;
`endif

endmodule

// File: tb/tb_baser_66b_mlane_checker.sv
module tb_baser_66b_mlane_checker;

   localparam int NL = 4;
   localparam int FW = 66;

   logic                clk = 1'b0;
   logic                i_rst;
   logic                i_valid;
   logic [NL*FW-1:0]    i_rx_coded;
   logic [NL-1:0]       o_block_lock;
   logic [31:0]         o_block_count, o_data_count, o_ctrl_count, o_inv_sh_count;
   logic [31:0]         o_inv_type_count, o_lock_loss_count, o_inv_pattern_count;

   always #5 clk = ~clk;

   baser_66b_mlane_checker dut (
      .clk                 (clk),
      .i_rst               (i_rst),
      .i_valid             (i_valid),
      .i_rx_coded          (i_rx_coded),
      .o_block_lock        (o_block_lock),
      .o_block_count       (o_block_count),
      .o_data_count        (o_data_count),
      .o_ctrl_count        (o_ctrl_count),
      .o_inv_sh_count      (o_inv_sh_count),
      .o_inv_type_count    (o_inv_type_count),
      .o_lock_loss_count   (o_lock_loss_count),
      .o_inv_pattern_count (o_inv_pattern_count)
   );

   typedef struct {
      logic [3:0]  lock;
      logic [31:0] blk, dat, ctl, ish, ity, ll, pat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // stimulus for the next cycle: header and 64-bit payload per lane
   logic [1:0]  s_hdr [NL];
   logic [63:0] s_pay [NL];

   // reference model state
   bit          m_lock [NL];
   int          m_run  [NL];
   int          m_win  [NL];
   int          m_bad  [NL];
   logic [31:0] m_blk, m_dat, m_ctl, m_ish, m_ity, m_ll, m_pat;

   logic [7:0] good_types [11] = '{8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
                                   8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

   function automatic logic [31:0] sadd(input logic [31:0] a, input int b);
      longint s;
      s = longint'(a) + longint'(b);
      if (s > 64'sd4294967295) return 32'hFFFF_FFFF;
      return 32'(s);
   endfunction

   function automatic bit type_known(input logic [7:0] t);
      foreach (good_types[i]) if (good_types[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task model_reset();
      for (int k = 0; k < NL; k++) begin
         m_lock[k] = 0; m_run[k] = 0; m_win[k] = 0; m_bad[k] = 0;
      end
      m_blk = 0; m_dat = 0; m_ctl = 0; m_ish = 0; m_ity = 0; m_ll = 0; m_pat = 0;
   endtask

   // One clock of stimulus; the expected post-edge outputs go to the queue.
   task step(input bit rst, input bit vld, input bit preload = 1'b0);
      int   n_dat, n_ctl, n_ish, n_ity, n_ll, n_pat;
      bit   good;
      exp_t e;
      @(negedge clk);
      if (preload) begin
         force dut.blk_cnt_p1 = 32'hFFFF_FFFE;
         force dut.dat_cnt_p1 = 32'hFFFF_FFFE;
         #1;
         release dut.blk_cnt_p1;
         release dut.dat_cnt_p1;
         m_blk = 32'hFFFF_FFFE;
         m_dat = 32'hFFFF_FFFE;
      end
      i_rst   = rst;
      i_valid = vld;
      for (int k = 0; k < NL; k++) i_rx_coded[k*FW +: FW] = {s_pay[k], s_hdr[k]};

      if (rst) begin
         model_reset();
      end else if (vld) begin
         n_dat = 0; n_ctl = 0; n_ish = 0; n_ity = 0; n_ll = 0; n_pat = 0;
         for (int k = 0; k < NL; k++) begin
            good = (s_hdr[k] == 2'b01) || (s_hdr[k] == 2'b10);
            if (s_hdr[k] == 2'b01) begin
               n_dat++;
               if (s_pay[k] != {8{8'hAA}}) n_pat++;
            end else if (s_hdr[k] == 2'b10) begin
               n_ctl++;
               if (!type_known(s_pay[k][7:0])) n_ity++;
            end else begin
               n_ish++;
            end
            if (!m_lock[k]) begin
               if (good) begin
                  m_run[k]++;
                  if (m_run[k] == 64) begin
                     m_lock[k] = 1; m_run[k] = 0; m_win[k] = 0; m_bad[k] = 0;
                  end
               end else begin
                  m_run[k] = 0;
               end
            end else begin
               if (!good) m_bad[k]++;
               if (m_bad[k] >= 16) begin
                  m_lock[k] = 0; m_win[k] = 0; m_bad[k] = 0; n_ll++;
               end else if (m_win[k] == 63) begin
                  m_win[k] = 0; m_bad[k] = 0;
               end else begin
                  m_win[k]++;
               end
            end
         end
         m_blk = sadd(m_blk, NL);
         m_dat = sadd(m_dat, n_dat);
         m_ctl = sadd(m_ctl, n_ctl);
         m_ish = sadd(m_ish, n_ish);
         m_ity = sadd(m_ity, n_ity);
         m_ll  = sadd(m_ll, n_ll);
`ifdef BASER_CHK_PATTERN_EN
         m_pat = sadd(m_pat, n_pat);
`endif
      end

      for (int k = 0; k < NL; k++) e.lock[k] = m_lock[k];
      e.blk = m_blk; e.dat = m_dat; e.ctl = m_ctl; e.ish = m_ish;
      e.ity = m_ity; e.ll = m_ll; e.pat = m_pat;
      q.push_back(e);
   endtask

   task set_all_data();
      for (int k = 0; k < NL; k++) begin
         s_hdr[k] = 2'b01;
         s_pay[k] = {8{8'hAA}};
      end
   endtask

   // monitor: registered outputs are checked one cycle after each stimulus
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("block_lock",   32'(o_block_lock), 32'(e.lock));
            chk("block_count",  o_block_count,       e.blk);
            chk("data_count",   o_data_count,        e.dat);
            chk("ctrl_count",   o_ctrl_count,        e.ctl);
            chk("inv_sh_count", o_inv_sh_count,      e.ish);
            chk("inv_type",     o_inv_type_count,    e.ity);
            chk("lock_loss",    o_lock_loss_count,   e.ll);
            chk("inv_pattern",  o_inv_pattern_count, e.pat);
         end
      end
   end

   initial begin
      int r;
      i_rst = 1'b1;
      i_valid = 1'b0;
      i_rx_coded = '0;
      set_all_data();
      model_reset();

      step(1, 0);
      step(1, 1);

      // clean data on all lanes until lock
      set_all_data();
      for (int i = 0; i < 64; i++) step(0, 1);
      step(0, 0);

      // lane 2 sees 16 consecutive bad headers and drops
      for (int i = 0; i < 16; i++) begin
         set_all_data();
         s_hdr[2] = 2'b00;
         step(0, 1);
      end

      // fresh lock, then 15 bad per window on lane 0 (held); lane 1 gets 15
      // bad ending on the window wrap (held), then 16 ending on it (lost)
      set_all_data();
      step(1, 1);
      for (int i = 0; i < 64; i++) step(0, 1);
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 64; i++) begin
            set_all_data();
            if (i < 15) s_hdr[0] = 2'b11;
            if ((w == 0 && i >= 49) || (w == 1 && i >= 48)) s_hdr[1] = 2'b00;
            step(0, 1);
         end
      end

      // unknown control type on lane 1
      set_all_data();
      s_hdr[1] = 2'b10;
      s_pay[1] = {56'h0, 8'h1F};
      step(0, 1);

      // wrong payload pattern on a data lane
      set_all_data();
      s_pay[3] = {8{8'h55}};
      step(0, 1);

      // reset wins over a valid cycle while lanes are locked
      set_all_data();
      step(1, 1);
      step(0, 0);

      // randomized traffic with occasional idle and reset cycles
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < NL; k++) begin
            r = $urandom_range(0, 99);
            if (r < 1)       s_hdr[k] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            else if (r < 30) s_hdr[k] = 2'b10;
            else             s_hdr[k] = 2'b01;
            s_pay[k] = {$urandom, $urandom};
            if (s_hdr[k] == 2'b10 && $urandom_range(0, 9) != 0)
               s_pay[k][7:0] = good_types[$urandom_range(0, 10)];
            if (s_hdr[k] == 2'b01 && $urandom_range(0, 99) < 85)
               s_pay[k] = {8{8'hAA}};
         end
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8);
      end

      // saturation from a preloaded near-max count, then reset mid-run
      set_all_data();
      step(0, 1, 1'b1);
      step(0, 1);
      step(1, 1);
      step(0, 0);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
